// File: rtl/dsp_pkg.sv
// dsp_pkg: shared op encoding and pipeline depth limits for the DSP MAC slice.
package dsp_pkg;

  localparam int unsigned DSP_OP_W = 2;

  // Legal accept-to-result latency range of dsp_mac_pipe.
  localparam int unsigned PIPE_STAGES_MIN = 2;
  localparam int unsigned PIPE_STAGES_MAX = 6;

  typedef enum logic [DSP_OP_W-1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } dsp_op_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: enable-gated valid + payload pipeline register, synchronous active-low reset.
// Bubbles (valid_i = 0) advance exactly like data; nothing moves while en_i is low.
module dsp_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  // Stage register: clear on reset, otherwise advance on enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pipelined multiply / multiply-accumulate slice with ready/valid flow control.
// Stage 0 captures operands, stages 1..PIPE_STAGES-1 carry the product, and the output register
// (stage PIPE_STAGES) applies the op against the accumulator.
// Build option: define DSP_MAC_SAT_EN to clamp the accumulator on MAC overflow instead of wrapping.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH_A     = 18,
  parameter int unsigned WIDTH_B     = 18,
  parameter int unsigned WIDTH_P     = 36,
  parameter int unsigned WIDTH_ACC   = 48,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   in_a,
  input  logic [WIDTH_B-1:0]   in_b,
  input  logic [DSP_OP_W-1:0]  in_op,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_p,
  output logic                 out_ovf
);

  // Out-of-range depths are clamped into the supported range.
  localparam int unsigned Stages = (PIPE_STAGES < PIPE_STAGES_MIN) ? PIPE_STAGES_MIN :
                                   (PIPE_STAGES > PIPE_STAGES_MAX) ? PIPE_STAGES_MAX :
                                   PIPE_STAGES;
  localparam int unsigned S0W = DSP_OP_W + 1 + WIDTH_A + WIDTH_B;
  localparam int unsigned SnW = DSP_OP_W + 1 + WIDTH_P;

  logic                 en;
  logic                 out_valid_q;
  logic [WIDTH_ACC-1:0] out_p_q;
  logic                 out_ovf_q;
  logic [WIDTH_ACC-1:0] acc_q;

  // One global enable: the whole pipe freezes only when a result is waiting and not taken.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------------------------------
  // Stage 0: operand capture
  // ---------------------------------------------------------------------------------------------
  logic           s0_valid;
  logic [S0W-1:0] s0_data;

  dsp_pipe_reg #(
    .Width (S0W)
  ) u_stage0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .valid_i (in_valid),
    .data_i  ({in_op, in_signed, in_a, in_b}),
    .valid_o (s0_valid),
    .data_o  (s0_data)
  );

  logic [DSP_OP_W-1:0] s0_op;
  logic                s0_sgn;
  logic [WIDTH_A-1:0]  s0_a;
  logic [WIDTH_B-1:0]  s0_b;

  assign {s0_op, s0_sgn, s0_a, s0_b} = s0_data;

  // ---------------------------------------------------------------------------------------------
  // Stage 1 input: multiply
  // ---------------------------------------------------------------------------------------------
  logic [WIDTH_P-1:0] a_ext;
  logic [WIDTH_P-1:0] b_ext;
  logic [WIDTH_P-1:0] prod;

  // Widen both operands to the product width first so a single modular multiply yields the
  // correct signed or unsigned WIDTH_P product.
  always_comb begin
    if (s0_sgn) begin
      a_ext = WIDTH_P'($signed(s0_a));
      b_ext = WIDTH_P'($signed(s0_b));
    end else begin
      a_ext = WIDTH_P'(s0_a);
      b_ext = WIDTH_P'(s0_b);
    end
    prod = a_ext * b_ext;
  end

  // ---------------------------------------------------------------------------------------------
  // Stages 1..Stages-1: product pipeline; the extra registers let synthesis retime the
  // multiplier across them.
  // ---------------------------------------------------------------------------------------------
  logic           st_valid [1:Stages-1];
  logic [SnW-1:0] st_data  [1:Stages-1];

  for (genvar i = 1; i < Stages; i++) begin : g_stage
    if (i == 1) begin : g_first
      dsp_pipe_reg #(
        .Width (SnW)
      ) u_reg (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .valid_i (s0_valid),
        .data_i  ({s0_op, s0_sgn, prod}),
        .valid_o (st_valid[i]),
        .data_o  (st_data[i])
      );
    end else begin : g_rest
      dsp_pipe_reg #(
        .Width (SnW)
      ) u_reg (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .valid_i (st_valid[i-1]),
        .data_i  (st_data[i-1]),
        .valid_o (st_valid[i]),
        .data_o  (st_data[i])
      );
    end
  end

  logic               fin_valid;
  logic [SnW-1:0]     fin_data;
  dsp_op_e            fin_op;
  logic               fin_sgn;
  logic [WIDTH_P-1:0] fin_prod;

  assign fin_valid = st_valid[Stages-1];
  assign fin_data  = st_data[Stages-1];
  assign fin_op    = dsp_op_e'(fin_data[SnW-1 -: DSP_OP_W]);
  assign fin_sgn   = fin_data[WIDTH_P];
  assign fin_prod  = fin_data[WIDTH_P-1:0];

  // ---------------------------------------------------------------------------------------------
  // Final stage: accumulate, overflow detect, optional saturation
  // ---------------------------------------------------------------------------------------------
`ifdef DSP_MAC_SAT_EN
  localparam logic [WIDTH_ACC-1:0] AccMaxU = '1;
  localparam logic [WIDTH_ACC-1:0] AccMaxS = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] AccMinS = {1'b1, {(WIDTH_ACC-1){1'b0}}};
`endif

  logic [WIDTH_ACC-1:0] prod_ext;
  logic [WIDTH_ACC:0]   sum_wide;
  logic [WIDTH_ACC-1:0] sum;
  logic                 mac_ovf;
  logic [WIDTH_ACC-1:0] mac_res;

  // Extend the product, add it to the accumulator and flag overflow in the beat's signedness.
  always_comb begin
    if (fin_sgn) begin
      prod_ext = WIDTH_ACC'($signed(fin_prod));
    end else begin
      prod_ext = WIDTH_ACC'(fin_prod);
    end
    sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
    sum      = sum_wide[WIDTH_ACC-1:0];
    if (fin_sgn) begin
      // Same-sign addends producing a different-sign sum.
      mac_ovf = (acc_q[WIDTH_ACC-1] == prod_ext[WIDTH_ACC-1]) &&
                (sum[WIDTH_ACC-1] != acc_q[WIDTH_ACC-1]);
    end else begin
      mac_ovf = sum_wide[WIDTH_ACC];
    end
    mac_res = sum;
`ifdef DSP_MAC_SAT_EN
    if (mac_ovf) begin
      if (!fin_sgn) begin
        mac_res = AccMaxU;
      end else if (acc_q[WIDTH_ACC-1]) begin
        // Signed overflow keeps the addends' sign: negative overflow clamps to min.
        mac_res = AccMinS;
      end else begin
        mac_res = AccMaxS;
      end
    end
`endif
  end

  logic [WIDTH_ACC-1:0] acc_d;
  logic [WIDTH_ACC-1:0] p_d;
  logic                 ovf_d;

  // Op decode for the beat entering the output register.
  always_comb begin
    acc_d = acc_q;
    p_d   = prod_ext;
    ovf_d = 1'b0;
    unique case (fin_op)
      OP_MUL: begin
        p_d = prod_ext;
      end
      OP_MAC: begin
        acc_d = mac_res;
        p_d   = mac_res;
        ovf_d = mac_ovf;
      end
      OP_LOAD: begin
        acc_d = prod_ext;
        p_d   = prod_ext;
      end
      OP_CLR: begin
        acc_d = '0;
        p_d   = '0;
      end
    endcase
  end

  // Output register and accumulator; the accumulator is written only here, so back-to-back
  // MACs always see the previous result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else if (en) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        acc_q     <= acc_d;
        out_p_q   <= p_d;
        out_ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: self-checking bench for dsp_mac_pipe. Two instances share every input:
// the default 48-bit accumulator and a 37-bit accumulator that overflows easily.
// Honours DSP_MAC_SAT_EN the same way as the design.
module tb_dsp_mac_pipe;
  import dsp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_signed;
  logic        out_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [1:0]  in_op;

  logic        in_ready;
  logic        out_valid;
  logic        out_ovf;
  logic [47:0] out_p;
  logic        in_ready37;
  logic        out_valid37;
  logic        out_ovf37;
  logic [36:0] out_p37;

  int errors = 0;
  int checks = 0;

`ifdef DSP_MAC_SAT_EN
  localparam logic [36:0] Ovf37Exp = 37'd137438953471;
`else
  localparam logic [36:0] Ovf37Exp = 37'd68717903875;
`endif

  dsp_mac_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_ovf   (out_ovf)
  );

  dsp_mac_pipe #(
    .WIDTH_ACC (37)
  ) u_dut37 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready37),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_signed (in_signed),
    .out_valid (out_valid37),
    .out_ready (out_ready),
    .out_p     (out_p37),
    .out_ovf   (out_ovf37)
  );

  // Reference model: exact integer arithmetic, results queued in acceptance order.
  typedef struct packed {
    logic [47:0] p48;
    logic        ovf48;
    logic [36:0] p37;
    logic        ovf37;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] acc48_m;
  logic [63:0] acc37_m;

  function automatic longint sval(input logic [63:0] x, input int w);
    if (x[w-1]) return longint'(x) - (longint'(1) <<< w);
    return longint'(x);
  endfunction

  task automatic model_step(input logic [1:0] op, input logic sgn, input logic [17:0] a,
                            input logic [17:0] b, input int w, input logic [63:0] acc_in,
                            output logic [63:0] acc_out, output logic [63:0] res,
                            output logic ovf);
    longint      pa, pb, s, vmax, vmin;
    logic [63:0] mask, ep, us;
    mask = (64'd1 << w) - 64'd1;
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    ep      = 64'(pa * pb) & mask;
    acc_out = acc_in;
    res     = ep;
    ovf     = 1'b0;
    case (op)
      OP_MAC: begin
        if (!sgn) begin
          us  = acc_in + ep;
          ovf = us > mask;
          res = us & mask;
`ifdef DSP_MAC_SAT_EN
          if (ovf) res = mask;
`endif
        end else begin
          vmax = (longint'(1) <<< (w - 1)) - 1;
          vmin = -(longint'(1) <<< (w - 1));
          s    = sval(acc_in, w) + sval(ep, w);
          ovf  = (s > vmax) || (s < vmin);
          res  = 64'(s) & mask;
`ifdef DSP_MAC_SAT_EN
          if (s > vmax) res = 64'(vmax) & mask;
          else if (s < vmin) res = 64'(vmin) & mask;
`endif
        end
        acc_out = res;
      end
      OP_LOAD: acc_out = ep;
      OP_CLR: begin
        acc_out = 64'd0;
        res     = 64'd0;
      end
      default: ;
    endcase
  endtask

  task automatic push_beat(input logic [1:0] op, input logic sgn, input logic [17:0] a,
                           input logic [17:0] b);
    exp_t        e;
    logic [63:0] r48, r37, n48, n37;
    logic        o48, o37;
    model_step(op, sgn, a, b, 48, acc48_m, n48, r48, o48);
    model_step(op, sgn, a, b, 37, acc37_m, n37, r37, o37);
    acc48_m = n48;
    acc37_m = n37;
    e.p48   = r48[47:0];
    e.ovf48 = o48;
    e.p37   = r37[36:0];
    e.ovf37 = o37;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, in_valid left high.
  task automatic send(input logic [1:0] op, input logic sgn, input logic [17:0] a,
                      input logic [17:0] b);
    int guard = 0;
    in_valid  = 1'b1;
    in_op     = op;
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      push_beat(op, sgn, a, b);
    end
    @(negedge clk);
  endtask

  task automatic settle;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_valid37 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b required 0/0", out_valid, out_valid37);
    end
    checks++;
    if (out_p !== 48'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: out_p=%0h ovf=%b required 0/0", out_p, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_latency;
    int n = 0;
    send(OP_MUL, 1'b0, 18'd10, 18'd20);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL mul_latency: edges after accept=%0d required 3", n);
    end
    checks++;
    if (out_p !== 48'd200 || out_ovf !== 1'b0 || out_p37 !== 37'd200) begin
      errors++;
      $display("FAIL mul_unsigned: out_p=%0d ovf=%b p37=%0d required 200/0/200",
               out_p, out_ovf, out_p37);
    end
    settle();
  endtask

  task automatic test_mul_signed;
    int n = 0;
    send(OP_MUL, 1'b1, 18'h3FFFD, 18'd5);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_p !== 48'hFFFF_FFFF_FFF1 || out_p37 !== 37'h1F_FFFF_FFF1) begin
      errors++;
      $display("FAIL mul_signed: v=%b out_p=%h p37=%h required 1/fffffffffff1/1ffffffff1",
               out_valid, out_p, out_p37);
    end
    settle();
  endtask

  task automatic test_mac_chain;
    int          n = 0;
    logic [47:0] want [3];
    want[0] = 48'd200;
    want[1] = 48'd5735;
    want[2] = 48'd95735;
    send(OP_LOAD, 1'b0, 18'd10, 18'd20);
    send(OP_MAC, 1'b0, 18'd123, 18'd45);
    send(OP_MAC, 1'b0, 18'd300, 18'd300);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_p !== want[i] || out_ovf !== 1'b0) begin
        errors++;
        $display("FAIL mac_chain[%0d]: v=%b out_p=%0d ovf=%b required 1/%0d/0",
                 i, out_valid, out_p, out_ovf, want[i]);
      end
      @(negedge clk);
    end
    settle();
  endtask

  task automatic test_backpressure;
    logic [47:0] held;
    exp_t        e;
    int          n;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_MUL, 1'b0, 18'($urandom), 18'($urandom));
    in_valid = 1'b0;
    held     = out_p;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_entry: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_p !== held) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b v=%b out_p=%0h required 0/1/%0h",
                 i, in_ready, out_valid, out_p, held);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (out_valid !== 1'b1 || out_p !== e.p48) begin
        errors++;
        $display("FAIL stall_order[%0d]: v=%b out_p=%0h required 1/%0h", i, out_valid, out_p,
                 e.p48);
      end
      @(negedge clk);
    end
    settle();
  endtask

  task automatic test_overflow;
    int          n = 0;
    logic [36:0] want [3];
    logic        wovf [3];
    want[0] = 37'd68718952449;
    want[1] = 37'd137437904898;
    want[2] = Ovf37Exp;
    wovf[0] = 1'b0;
    wovf[1] = 1'b0;
    wovf[2] = 1'b1;
    send(OP_LOAD, 1'b0, 18'h3FFFF, 18'h3FFFF);
    send(OP_MAC, 1'b0, 18'h3FFFF, 18'h3FFFF);
    send(OP_MAC, 1'b0, 18'h3FFFF, 18'h3FFFF);
    in_valid = 1'b0;
    while (!out_valid37 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid37 !== 1'b1 || out_p37 !== want[i] || out_ovf37 !== wovf[i]) begin
        errors++;
        $display("FAIL ovf37[%0d]: v=%b out_p=%0d ovf=%b required 1/%0d/%b",
                 i, out_valid37, out_p37, out_ovf37, want[i], wovf[i]);
      end
      if (i == 2) begin
        checks++;
        if (out_p !== 48'd206156857347 || out_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf48_none: out_p=%0d ovf=%b required 206156857347/0", out_p, out_ovf);
        end
      end
      @(negedge clk);
    end
    settle();
  endtask

  task automatic test_reset_inflight;
    int seen = 0;
    int n    = 0;
    send(OP_MUL, 1'b0, 18'd7, 18'd9);
    send(OP_MUL, 1'b0, 18'd11, 18'd13);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    acc48_m = 64'd0;
    acc37_m = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid || out_valid37) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_flush: out_valid seen %0d cycles required 0", seen);
    end
    send(OP_MAC, 1'b0, 18'd2, 18'd3);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_p !== 48'd6 || out_p37 !== 37'd6) begin
      errors++;
      $display("FAIL reset_mac: v=%b out_p=%0d p37=%0d required 1/6/6", out_valid, out_p,
               out_p37);
    end
    settle();
  endtask

  function automatic logic [17:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 18'h3FFFF;
      1:       return 18'h20000;
      2:       return 18'h1FFFF;
      3:       return 18'($urandom_range(0, 15));
      default: return 18'($urandom);
    endcase
  endfunction

  function automatic logic [1:0] rand_op();
    int r = $urandom_range(0, 9);
    if (r < 5) return OP_MAC;
    if (r < 7) return OP_MUL;
    if (r < 9) return OP_LOAD;
    return OP_CLR;
  endfunction

  task automatic test_random;
    localparam int N = 300;
    int   sent = 0;
    int   cyc = 0;
    logic accepted = 1'b0;
    exp_t e;
    in_valid = 1'b0;
    while ((sent < N || exp_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (accepted) begin
        in_valid = 1'b0;
        accepted = 1'b0;
      end
      out_ready = (sent < N) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!in_valid && sent < N && $urandom_range(0, 4) != 0) begin
        in_valid  = 1'b1;
        in_op     = rand_op();
        in_signed = 1'($urandom);
        in_a      = rand_operand();
        in_b      = rand_operand();
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: unexpected result out_p=%0h", out_p);
        end else begin
          e = exp_q.pop_front();
          if (out_p !== e.p48 || out_ovf !== e.ovf48 || out_valid37 !== 1'b1 ||
              out_p37 !== e.p37 || out_ovf37 !== e.ovf37) begin
            errors++;
            $display("FAIL rand_result: got %h/%b %h/%b required %h/%b %h/%b", out_p, out_ovf,
                     out_p37, out_ovf37, e.p48, e.ovf48, e.p37, e.ovf37);
          end
        end
      end
      if (in_valid && in_ready) begin
        push_beat(in_op, in_signed, in_a, in_b);
        sent++;
        accepted = 1'b1;
      end
    end
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL rand_timeout: sent=%0d pending=%0d required all delivered", sent,
               exp_q.size());
    end
    settle();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_signed = 1'b0;
    in_a      = 18'd0;
    in_b      = 18'd0;
    out_ready = 1'b1;
    acc48_m   = 64'd0;
    acc37_m   = 64'd0;
    test_reset();
    test_mul_latency();
    test_mul_signed();
    test_mac_chain();
    test_backpressure();
    test_overflow();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
